// File: rtl/disp_pkg.sv
// Shared display types and codes for the display arbiter slice.
// Blank and minus codes match the seven-segment driver's decoder.
package disp_pkg;

   typedef enum logic [1:0] {
      S_ENTRY  = 2'b00,
      S_RESULT = 2'b01,
      S_ERROR  = 2'b10
   } state_t;

   localparam logic [3:0]  DIG_MINUS   = 4'hE;
   localparam logic [3:0]  DIG_BLANK   = 4'hF;
   localparam logic [15:0] ERR_PATTERN = 16'hEEEE;

   // A negative result shows a minus in the most significant digit.
   function automatic logic [15:0] insert_sign(input logic [15:0] mag, input logic neg);
      logic [15:0] v;
      if (neg) begin
         v = {DIG_MINUS, mag[11:0]};
      end else begin
         v = mag;
      end
      return v;
   endfunction

endpackage

// File: rtl/display_arbiter_lz_blanker.sv
// Leading-zero blanking for a 4-digit BCD word; digit 0 always shown.
// A leading minus is kept and the zeros that follow it are blanked.
module lz_blanker
   import disp_pkg::*;
(
   input  logic [15:0] i_bcd,
   output logic [15:0] o_bcd
);

   logic [15:0] w_out;
   logic        w_leading;

   // Walk from the top digit down, blanking zeros until a significant digit.
   always_comb begin
      w_out     = i_bcd;
      w_leading = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         if (w_leading && (i_bcd[i*4 +: 4] == 4'h0)) begin
            w_out[i*4 +: 4] = DIG_BLANK;
         end else if ((i == 3) && (i_bcd[15:12] == DIG_MINUS)) begin
            w_leading = 1'b1;
         end else begin
            w_leading = 1'b0;
         end
      end
   end

   assign o_bcd = w_out;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the shared BCD display bus between live entry, ALU results and timed errors.
// Optional leading-zero blanking is enabled by defining DISPLAY_LZB_EN.
module display_arbiter
   import disp_pkg::*;
#(
   parameter int HOLD_CYCLES = 100_000_000,
   parameter int TIMER_W     = 27
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] entry_bcd,
   input  logic        key_evt,
   input  logic        clr,
   input  logic [15:0] res_bcd,
   input  logic        res_neg,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic        err_pulse,
   output logic [15:0] bcd_out,
   output logic [1:0]  mode
);

   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
`ifdef DISPLAY_LZB_EN
   localparam logic [15:0] BCD_RST = 16'hFFF0;
`else
   localparam logic [15:0] BCD_RST = 16'h0000;
`endif

   state_t             r_state;
   logic [TIMER_W-1:0] r_timer;
   logic [15:0]        r_res_bcd;
   logic               r_res_neg;
   logic [15:0]        r_bcd_out;

   state_t             w_state_nxt;
   logic [TIMER_W-1:0] w_timer_nxt;
   logic [15:0]        w_res_bcd_nxt;
   logic               w_res_neg_nxt;
   logic [15:0]        w_disp_raw;
   logic [15:0]        w_disp;
   logic               w_accept;
   logic               w_res_bad;

   assign res_ready = (!rst) && (r_state != S_ERROR);
   assign w_accept  = res_valid && res_ready;
   // A minus needs digit 3, so a negative magnitude using it cannot be shown.
   assign w_res_bad = res_neg && (res_bcd[15:12] != 4'h0);

   // Next-state arbitration in priority order: clr, err_pulse, accept, hold timer, key.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_res_bcd_nxt = r_res_bcd;
      w_res_neg_nxt = r_res_neg;
      if (clr) begin
         w_state_nxt   = S_ENTRY;
         w_timer_nxt   = TIMER_ZERO;
         w_res_bcd_nxt = 16'h0000;
         w_res_neg_nxt = 1'b0;
      end else if (err_pulse) begin
         w_state_nxt = S_ERROR;
         w_timer_nxt = TIMER_LOAD;
      end else if (w_accept) begin
         if (w_res_bad) begin
            w_state_nxt = S_ERROR;
            w_timer_nxt = TIMER_LOAD;
         end else begin
            w_state_nxt   = S_RESULT;
            w_res_bcd_nxt = res_bcd;
            w_res_neg_nxt = res_neg;
         end
      end else if (r_state == S_ERROR) begin
         if (r_timer == TIMER_ZERO) begin
            w_state_nxt = S_ENTRY;
         end else begin
            w_timer_nxt = r_timer - {{(TIMER_W-1){1'b0}}, 1'b1};
         end
      end else if (key_evt) begin
         w_state_nxt = S_ENTRY;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Select the word that the next state will show.
   always_comb begin
      case (w_state_nxt)
         S_ENTRY:  w_disp_raw = entry_bcd;
         S_RESULT: w_disp_raw = insert_sign(w_res_bcd_nxt, w_res_neg_nxt);
         S_ERROR:  w_disp_raw = ERR_PATTERN;
         default:  w_disp_raw = entry_bcd;
      endcase
   end

`ifdef DISPLAY_LZB_EN
   logic [15:0] w_lzb;

   lz_blanker u_lz_blanker (
      .i_bcd (w_disp_raw),
      .o_bcd (w_lzb)
   );

   // The error pattern bypasses blanking.
   always_comb begin
      if (w_state_nxt == S_ERROR) begin
         w_disp = w_disp_raw;
      end else begin
         w_disp = w_lzb;
      end
   end
`else
   assign w_disp = w_disp_raw;
`endif

   // State, hold timer, result latch and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_ENTRY;
         r_timer   <= TIMER_ZERO;
         r_res_bcd <= 16'h0000;
         r_res_neg <= 1'b0;
         r_bcd_out <= BCD_RST;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_res_bcd <= w_res_bcd_nxt;
         r_res_neg <= w_res_neg_nxt;
         r_bcd_out <= w_disp;
      end
   end

   assign bcd_out = r_bcd_out;
   assign mode    = r_state;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with a short error hold (8 cycles).
// Expected display words are written unblanked and blanked by a reference when DISPLAY_LZB_EN is set.
module tb_display_arbiter;

   typedef struct {
      logic        rst, clr, key, err, rv, rneg;
      logic [15:0] rbcd, entry;
      logic        exp_ready;
      logic [15:0] exp_bcd;
      logic [1:0]  exp_mode;
   } vec_t;

   typedef struct {
      logic [15:0] bcd;
      logic [1:0]  mode;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, key_evt, clr, res_neg, res_valid, err_pulse;
   logic [15:0] entry_bcd, res_bcd;
   logic        res_ready;
   logic [15:0] bcd_out;
   logic [1:0]  mode;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   vec_t tbl[11];

   display_arbiter #(.HOLD_CYCLES(8), .TIMER_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .entry_bcd (entry_bcd),
      .key_evt   (key_evt),
      .clr       (clr),
      .res_bcd   (res_bcd),
      .res_neg   (res_neg),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .err_pulse (err_pulse),
      .bcd_out   (bcd_out),
      .mode      (mode)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_disp(input logic [15:0] raw);
      logic [15:0] r;
      int          top;
      r = raw;
`ifdef DISPLAY_LZB_EN
      top = (raw[15:12] == 4'hE) ? 2 : 3;
      for (int i = top; i >= 1; i--) begin
         if (r[i*4 +: 4] != 4'h0) break;
         r[i*4 +: 4] = 4'hF;
      end
`else
      top = 0;
`endif
      return r;
   endfunction

   function automatic vec_t mk(input logic r, c, k, e, v, n, input logic [15:0] rb, en,
                               input logic rdy, input logic [15:0] eb, input logic [1:0] em);
      vec_t t;
      t.rst = r; t.clr = c; t.key = k; t.err = e; t.rv = v; t.rneg = n;
      t.rbcd = rb; t.entry = en; t.exp_ready = rdy; t.exp_bcd = eb; t.exp_mode = em;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   // Drive one cycle, check res_ready before the edge and the registered outputs after it.
   task automatic step(input vec_t v, input int idx);
      exp_t e;
      rst = v.rst; clr = v.clr; key_evt = v.key; err_pulse = v.err;
      res_valid = v.rv; res_neg = v.rneg; res_bcd = v.rbcd; entry_bcd = v.entry;
      #1;
      chk("res_ready", idx, {15'h0000, res_ready}, {15'h0000, v.exp_ready});
      e.bcd  = exp_disp(v.exp_bcd);
      e.mode = v.exp_mode;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", idx, 16'h0001, 16'h0000);
      end else begin
         e = sb.pop_front();
         chk("bcd_out", idx, bcd_out, e.bcd);
         chk("mode", idx, {14'h0000, mode}, {14'h0000, e.mode});
      end
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; key_evt = 1'b0; err_pulse = 1'b0;
      res_valid = 1'b0; res_neg = 1'b0; res_bcd = 16'h0000; entry_bcd = 16'h0000;

      //            rst clr key err rv  neg rbcd      entry     rdy  exp_bcd   mode
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0123, 0, 16'h0000, 2'd0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0123, 1, 16'h0123, 2'd0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0456, 1, 16'h0456, 2'd0);
      tbl[3]  = mk(0, 0, 0, 0, 1, 1, 16'h0042, 16'h0456, 1, 16'hE042, 2'd1);
      tbl[4]  = mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 1, 16'hE042, 2'd1);
      tbl[5]  = mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0777, 1, 16'h0777, 2'd0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 0, 16'h1234, 16'h0777, 1, 16'h1234, 2'd1);
      tbl[7]  = mk(0, 0, 0, 0, 1, 0, 16'h0999, 16'h0777, 1, 16'h0999, 2'd1);
      tbl[8]  = mk(0, 0, 0, 0, 1, 1, 16'h1234, 16'h0777, 1, 16'hEEEE, 2'd2);
      tbl[9]  = mk(0, 1, 0, 0, 1, 0, 16'h0555, 16'h0777, 0, 16'h0777, 2'd0);
      tbl[10] = mk(0, 0, 1, 1, 1, 0, 16'h0555, 16'h0777, 1, 16'hEEEE, 2'd2);

      for (int i = 0; i < 11; i++) step(tbl[i], i);

      // Remainder of the hold started above: keys and results ignored, then entry resumes.
      for (int i = 0; i < 7; i++)
         step(mk(0, 0, 1, 0, 1, 0, 16'h0555, 16'h0777, 0, 16'hEEEE, 2'd2), 100 + i);
      step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 0, 16'h0777, 2'd0), 107);
      step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 1, 16'h0777, 2'd0), 108);

      // Second error pulse on the fifth hold cycle restarts the full hold.
      step(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0777, 1, 16'hEEEE, 2'd2), 200);
      for (int i = 0; i < 4; i++)
         step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 0, 16'hEEEE, 2'd2), 201 + i);
      step(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0777, 0, 16'hEEEE, 2'd2), 205);
      for (int i = 0; i < 7; i++)
         step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 0, 16'hEEEE, 2'd2), 206 + i);
      step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 0, 16'h0777, 2'd0), 213);

      // Reset while showing a result.
      step(mk(0, 0, 0, 0, 1, 0, 16'h0042, 16'h0777, 1, 16'h0042, 2'd1), 300);
      step(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 0, 16'h0000, 2'd0), 301);
      step(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0777, 1, 16'h0777, 2'd0), 302);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
